// File: rtl/booth_mac_acc_if.sv
// Handshake bundle between the Booth multiplier stage and the block accumulator.
// master drives products and the downstream ready; slave is the accumulator.
interface booth_mac_acc_if #(
    parameter int WIDTH = 6,
    parameter int ACC_W = 16,
    parameter int CNT_W = 3
);
    logic signed [2*WIDTH-1:0] prod;
    logic                      in_valid;
    logic                      in_ready;
    logic                      clr;
    logic signed [ACC_W-1:0]   acc_out;
    logic                      out_valid;
    logic                      out_ready;
    logic [CNT_W-1:0]          count;
    logic                      ovf;

    modport master (
        output prod, in_valid, clr, out_ready,
        input  in_ready, acc_out, out_valid, count, ovf
    );

    modport slave (
        input  prod, in_valid, clr, out_ready,
        output in_ready, acc_out, out_valid, count, ovf
    );
endinterface

// File: rtl/booth_mac_acc.sv
// Block accumulator for signed Booth multiplier products.
// Sums LEN products, presents the sum on a held output handshake, then clears.
// Optional macro BOOTH_MAC_SAT_EN: clamp on signed overflow instead of wrapping.
module booth_mac_acc #(
    parameter int WIDTH = 6,
    parameter int ACC_W = 16,
    parameter int LEN   = 4,
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    booth_mac_acc_if.slave    bus
);
    localparam logic [0:0] ST_ACC = 1'b0;
    localparam logic [0:0] ST_OUT = 1'b1;

    logic [0:0]              state_p1;
    logic signed [ACC_W-1:0] acc_p1;
    logic [CNT_W-1:0]        count_p1;
    logic                    ovf_p1;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] raw_sum;
    logic signed [ACC_W-1:0] next_sum;
    logic                    ovf_hit;
    logic                    take_in;
    logic                    take_out;
    logic                    last_in;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                     input logic signed [ACC_W-1:0] b,
                                     input logic signed [ACC_W-1:0] s);
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

    // Accumulator add; wraps by default, clamps to the rails when saturation is built in.
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W-1:0] s;
        s = a + b;
`ifdef BOOTH_MAC_SAT_EN
        if (add_ovf(a, b, s)) begin
            s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    // Size cast of a signed operand sign-extends, and stays legal when ACC_W == 2*WIDTH.
    assign prod_ext = ACC_W'(bus.prod);
    assign raw_sum  = acc_p1 + prod_ext;
    assign next_sum = sat_add(acc_p1, prod_ext);
    assign ovf_hit  = add_ovf(acc_p1, prod_ext, raw_sum);

    assign take_in  = bus.in_valid && (state_p1 == ST_ACC);
    assign take_out = bus.out_ready && (state_p1 == ST_OUT);
    assign last_in  = (count_p1 == CNT_W'(LEN - 1));

    // Block state machine: accumulate LEN products, then hold the sum until taken.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            state_p1 <= ST_ACC;
            acc_p1   <= '0;
            count_p1 <= '0;
            ovf_p1   <= 1'b0;
        end else begin
            case (state_p1)
                ST_ACC: begin
                    if (take_in) begin
                        acc_p1   <= next_sum;
                        count_p1 <= count_p1 + 1'b1;
                        if (ovf_hit) begin
                            ovf_p1 <= 1'b1;
                        end
                        if (last_in) begin
                            state_p1 <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (take_out) begin
                        state_p1 <= ST_ACC;
                        acc_p1   <= '0;
                        count_p1 <= '0;
                        ovf_p1   <= 1'b0;
                    end
                end
                default: begin
                    state_p1 <= ST_ACC;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_p1 == ST_ACC);
    assign bus.out_valid = (state_p1 == ST_OUT);
    assign bus.acc_out   = acc_p1;
    assign bus.count     = count_p1;
    assign bus.ovf       = ovf_p1;
endmodule

// File: tb/tb_booth_mac_acc.sv
// Directed bench for booth_mac_acc: defaults, narrow accumulator, and LEN=1 instances.
module tb_booth_mac_acc;
    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    booth_mac_acc_if #(.WIDTH(6), .ACC_W(16), .CNT_W(3)) bus0 ();
    booth_mac_acc_if #(.WIDTH(6), .ACC_W(12), .CNT_W(3)) bus1 ();
    booth_mac_acc_if #(.WIDTH(6), .ACC_W(16), .CNT_W(1)) bus2 ();

    booth_mac_acc #(.WIDTH(6), .ACC_W(16), .LEN(4)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    booth_mac_acc #(.WIDTH(6), .ACC_W(12), .LEN(4)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
    booth_mac_acc #(.WIDTH(6), .ACC_W(16), .LEN(1)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    // Advance one edge; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input int v);
        bus0.in_valid = 1'b1;
        bus0.prod     = 12'(v);
        tick();
        bus0.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        bus0.in_valid = 1'b1; bus0.prod = 12'(9); bus0.clr = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.prod = '0;     bus1.clr = 1'b0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.prod = '0;     bus2.clr = 1'b0; bus2.out_ready = 1'b0;
        tick(); tick();
        bus0.in_valid = 1'b0;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        total++; if (bus0.acc_out !== 16'sd0) begin bad++; $display("FAIL reset_acc got=%0d exp=0", bus0.acc_out); end
        total++; if (bus0.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus0.count); end
        total++; if (bus0.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", bus0.ovf); end
        total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", bus0.out_valid); end
        total++; if (bus0.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", bus0.in_ready); end
        total++; if (bus1.acc_out !== 12'sd0) begin bad++; $display("FAIL reset_acc1 got=%0d exp=0", bus1.acc_out); end
    endtask

    task automatic test_block();
        bus0.out_ready = 1'b0;
        push0(10);
        total++; if (bus0.acc_out !== 16'sd10 || bus0.count !== 3'd1) begin bad++; $display("FAIL block_first got=%0d/%0d exp=10/1", bus0.acc_out, bus0.count); end
        push0(-3);
        push0(25);
        total++; if (bus0.out_valid !== 1'b0 || bus0.acc_out !== 16'sd32) begin bad++; $display("FAIL block_third got=%0d ov=%0b exp=32 ov=0", bus0.acc_out, bus0.out_valid); end
        push0(0);
        total++; if (bus0.out_valid !== 1'b1) begin bad++; $display("FAIL block_out_valid got=%0b exp=1", bus0.out_valid); end
        total++; if (bus0.acc_out !== 16'sd32) begin bad++; $display("FAIL block_sum got=%0d exp=32", bus0.acc_out); end
        total++; if (bus0.count !== 3'd4) begin bad++; $display("FAIL block_count got=%0d exp=4", bus0.count); end
        total++; if (bus0.ovf !== 1'b0 || bus0.in_ready !== 1'b0) begin bad++; $display("FAIL block_flags got ovf=%0b rdy=%0b exp ovf=0 rdy=0", bus0.ovf, bus0.in_ready); end
    endtask

    task automatic test_hold();
        bus0.in_valid = 1'b1;
        bus0.prod     = 12'(99);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bus0.acc_out !== 16'sd32 || bus0.out_valid !== 1'b1 || bus0.count !== 3'd4) begin
                bad++; $display("FAIL hold_stable cyc=%0d got=%0d ov=%0b cnt=%0d exp=32 ov=1 cnt=4", i, bus0.acc_out, bus0.out_valid, bus0.count);
            end
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        tick();
        total++; if (bus0.acc_out !== 16'sd0 || bus0.count !== 3'd0) begin bad++; $display("FAIL hold_clear got=%0d/%0d exp=0/0", bus0.acc_out, bus0.count); end
        total++; if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin bad++; $display("FAIL hold_ready got rdy=%0b ov=%0b exp rdy=1 ov=0", bus0.in_ready, bus0.out_valid); end
        bus0.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push0(-1024);
        total++; if ($signed(bus0.acc_out) !== -4096 || bus0.out_valid !== 1'b1) begin bad++; $display("FAIL hold_neg_block got=%0d ov=%0b exp=-4096 ov=1", bus0.acc_out, bus0.out_valid); end
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
        total++; if (bus0.count !== 3'd0 || bus0.out_valid !== 1'b0) begin bad++; $display("FAIL hold_drain got cnt=%0d ov=%0b exp cnt=0 ov=0", bus0.count, bus0.out_valid); end
    endtask

    task automatic test_overflow();
        int exp_sum[4];
`ifdef BOOTH_MAC_SAT_EN
        exp_sum = '{1024, 2047, 2047, 2047};
`else
        exp_sum = '{1024, -2048, -1024, 0};
`endif
        bus1.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus1.in_valid = 1'b1;
            bus1.prod     = 12'(1024);
            tick();
            total++;
            if ($signed(bus1.acc_out) !== exp_sum[i]) begin
                bad++; $display("FAIL ovf_running step=%0d got=%0d exp=%0d", i, bus1.acc_out, exp_sum[i]);
            end
        end
        bus1.in_valid = 1'b0;
        total++; if (bus1.ovf !== 1'b1 || bus1.out_valid !== 1'b1) begin bad++; $display("FAIL ovf_flag got ovf=%0b ov=%0b exp ovf=1 ov=1", bus1.ovf, bus1.out_valid); end
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        total++; if (bus1.ovf !== 1'b0 || bus1.acc_out !== 12'sd0) begin bad++; $display("FAIL ovf_cleared got ovf=%0b acc=%0d exp ovf=0 acc=0", bus1.ovf, bus1.acc_out); end
    endtask

    task automatic test_clr();
        push0(100);
        push0(200);
        total++; if (bus0.acc_out !== 16'sd300 || bus0.count !== 3'd2) begin bad++; $display("FAIL clr_pre got=%0d/%0d exp=300/2", bus0.acc_out, bus0.count); end
        bus0.clr      = 1'b1;
        bus0.in_valid = 1'b1;
        bus0.prod     = 12'(7);
        tick();
        bus0.clr      = 1'b0;
        bus0.in_valid = 1'b0;
        total++; if (bus0.acc_out !== 16'sd0 || bus0.count !== 3'd0 || bus0.ovf !== 1'b0) begin bad++; $display("FAIL clr_cleared got acc=%0d cnt=%0d ovf=%0b exp 0/0/0", bus0.acc_out, bus0.count, bus0.ovf); end
        push0(1); push0(2); push0(3); push0(4);
        total++; if (bus0.acc_out !== 16'sd10 || bus0.out_valid !== 1'b1) begin bad++; $display("FAIL clr_next_block got=%0d ov=%0b exp=10 ov=1", bus0.acc_out, bus0.out_valid); end
        bus0.clr = 1'b1;
        tick();
        bus0.clr = 1'b0;
        total++; if (bus0.out_valid !== 1'b0 || bus0.acc_out !== 16'sd0) begin bad++; $display("FAIL clr_in_out got ov=%0b acc=%0d exp ov=0 acc=0", bus0.out_valid, bus0.acc_out); end
    endtask

    task automatic test_rst_in_out();
        bus0.out_ready = 1'b0;
        push0(10); push0(-3); push0(25); push0(0);
        total++; if (bus0.acc_out !== 16'sd32 || bus0.out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre got=%0d ov=%0b exp=32 ov=1", bus0.acc_out, bus0.out_valid); end
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        total++; if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin bad++; $display("FAIL rst_flags got ov=%0b rdy=%0b exp ov=0 rdy=1", bus0.out_valid, bus0.in_ready); end
        total++; if (bus0.acc_out !== 16'sd0 || bus0.count !== 3'd0) begin bad++; $display("FAIL rst_regs got=%0d/%0d exp=0/0", bus0.acc_out, bus0.count); end
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 7; i++) begin
            bus0.in_valid = (i % 2 == 0);
            bus0.prod     = (i % 2 == 0) ? 12'(-5) : 12'(50);
            tick();
            if (i == 1) begin
                total++; if ($signed(bus0.acc_out) !== -5 || bus0.count !== 3'd1) begin bad++; $display("FAIL gap_hold got=%0d/%0d exp=-5/1", bus0.acc_out, bus0.count); end
            end
        end
        bus0.in_valid = 1'b0;
        total++; if ($signed(bus0.acc_out) !== -20 || bus0.count !== 3'd4 || bus0.out_valid !== 1'b1) begin bad++; $display("FAIL gap_sum got=%0d cnt=%0d ov=%0b exp=-20 cnt=4 ov=1", bus0.acc_out, bus0.count, bus0.out_valid); end
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_len1();
        bus2.out_ready = 1'b0;
        bus2.in_valid  = 1'b1;
        bus2.prod      = 12'(-7);
        tick();
        bus2.in_valid  = 1'b0;
        total++; if ($signed(bus2.acc_out) !== -7 || bus2.out_valid !== 1'b1 || bus2.count !== 1'b1) begin bad++; $display("FAIL len1_out got=%0d ov=%0b cnt=%0d exp=-7 ov=1 cnt=1", bus2.acc_out, bus2.out_valid, bus2.count); end
        bus2.out_ready = 1'b1;
        tick();
        bus2.out_ready = 1'b0;
        total++; if (bus2.acc_out !== 16'sd0 || bus2.in_ready !== 1'b1) begin bad++; $display("FAIL len1_clear got=%0d rdy=%0b exp=0 rdy=1", bus2.acc_out, bus2.in_ready); end
    endtask

    initial begin
        test_reset();
        test_block();
        test_hold();
        test_overflow();
        test_clr();
        test_rst_in_out();
        test_gapped();
        test_len1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
